lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit on the initiator side of the data-memory interface. Takes one load or store per handshake from the core. Produces a word-aligned bus request with byte strobes and replicated write data, waits for the memory's response, then returns sign- or zero-extended load data or an error to the core. Sits between the execute stage and the data memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_R before aborting the load with an error.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  LSU can accept a request; high only in IDLE
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_memop  in  3  000 byte signed, 100 byte unsigned, 001 half signed, 101 half unsigned, 010 word
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access, illegal memop, or timeout; valid with resp_valid
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  memory accepts the request
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wen  out  1  store request
mem_wstrb  out  4  byte lanes; 0000 for loads
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  load data valid
mem_rdata  in  32  full aligned word, little-endian lanes

Behaviour:
- Reset: state IDLE; timeout counter 0; all outputs 0 except req_ready=1. Reset mid-transaction drops the transaction with no response. Any mem_rvalid that arrives after reset is ignored.
- Accept: a request is accepted when req_valid & req_ready. All request fields are registered on acceptance.
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE to RESP: on accept if the request is misaligned or the memop is illegal (011, 110, 111). In that case resp_err=1 and no bus activity occurs.
- Alignment rules: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
- IDLE to REQ: on any other accept.
- REQ: mem_req_valid=1 and all mem_* outputs are held stable until mem_req_ready.
  - Store with ready: go to RESP.
  - Load with ready: go to WAIT_R.
- WAIT_R: count cycles.
  - On mem_rvalid: capture the extended data and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES before mem_rvalid: go to RESP with resp_err=1 and rdata=0.
  - mem_rvalid arriving in the same cycle the limit is hit counts as success.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The core has no backpressure on the response.
- Latency with zero-wait memory:
  - store: accept at cycle 0, mem_req_valid at cycle 1, resp_valid at cycle 2;
  - load with mem_rvalid at cycle 2: resp_valid at cycle 3;
  - error: resp_valid at cycle 1.
- Strobes (k = addr[1:0]): byte 0001<<k; half 0011<<k; word 1111.
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction: shift mem_rdata right by 8*k, take the low 8/16/32 bits, then extend per memop bit 2 (1 = zero, 0 = sign).
- req_ready is low in REQ, WAIT_R and RESP. A new request can be accepted in the cycle after RESP.

Decomposition:
- Package lsu_pkg holds:
  - memop localparams MEMOP_B=000, MEMOP_BU=100, MEMOP_H=001, MEMOP_HU=101, MEMOP_W=010;
  - the state encoding (IDLE, REQ, WAIT_R, RESP);
  - a function is_misaligned(memop, addr[1:0]).
- Sub-module lsu_align (purely combinational) contains the strobe generation, write-data replication and load extraction/extension. lsu_ctrl contains the FSM, registers and timeout counter.

Test Plan:
- Store byte: addr 0x1003, wdata 0x000000A5, memop 000, mem_req_ready at once -> mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5; resp_valid at cycle 2 with err=0.
- Signed and unsigned half load: addr 0x2002, mem_rdata 0x8001_1234. memop 001 -> rdata 0xFFFF8001. memop 101 -> 0x00008001.
- Word load with 5 cycles of mem_req_ready=0 and 3 cycles of rvalid delay, mem_rdata 0xDEADBEEF -> mem_* outputs stable throughout the stall; rdata 0xDEADBEEF; req_ready low until RESP completes.
- Misaligned word at 0x3001, and illegal memop 111 -> resp_valid at cycle 1 with err=1; mem_req_valid never asserted.
- Timeout with TIMEOUT_CYCLES=4 and mem_rvalid never asserted -> resp_err=1, rdata=0 after 4 WAIT_R cycles; next request accepted normally.
- rst pulsed while in WAIT_R, then mem_rvalid arrives -> no resp_valid; state IDLE; req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared memop encodings, FSM state type and access-legality helpers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_W  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic is_illegal(input logic [2:0] memop);
        return (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111);
    endfunction

    // Byte accesses are always aligned; illegal memops are rejected separately.
    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
        logic v;
        v = 1'b0;
        if (memop == MEMOP_W)
            v = (addr_lo != 2'b00);
        else if ((memop == MEMOP_H) || (memop == MEMOP_HU))
            v = addr_lo[0];
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-lane strobes, write-data replication and load extraction
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_memop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // memop[2] selects zero extension; memop[1:0] selects the access size.
    always_comb begin
        w_shifted = i_rdata >> {i_addr_lo, 3'b000};
        o_wstrb   = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = w_shifted;
        case (i_memop[1:0])
            MEMOP_B[1:0]: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_memop[2] & w_shifted[7]}}, w_shifted[7:0]};
            end
            MEMOP_H[1:0]: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_memop[2] & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit: core handshake, aligned bus request, response
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e       r_state;
    lsu_state_e       w_state_nxt;
    logic             r_wen;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_memop;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_bad;
    logic             w_timeout;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata_ext;

    assign w_accept  = req_valid & req_ready;
    assign w_bad     = is_illegal(req_memop) | is_misaligned(req_memop, req_addr[1:0]);
    // Last permitted WAIT_R cycle; rvalid in this cycle still wins.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .i_memop   (r_memop),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_memop <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wen   <= req_wen;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_memop <= req_memop;
                r_rdata <= '0;
                r_err   <= w_bad;
            end
            if (r_state == ST_WAIT_R) begin
                r_cnt <= r_cnt + 1'b1;
                if (mem_rvalid)
                    r_rdata <= w_rdata_ext;
                else if (w_timeout)
                    r_err <= 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_err      = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wstrb     = 4'b0000;
        mem_wdata     = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_nxt = w_bad ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {r_addr[31:2], 2'b00};
                mem_wen       = r_wen;
                mem_wstrb     = r_wen ? w_wstrb : 4'b0000;
                mem_wdata     = r_wen ? w_wdata : 32'h0;
                if (mem_req_ready)
                    w_state_nxt = r_wen ? ST_RESP : ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (mem_rvalid || w_timeout)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                resp_rdata  = r_rdata;
                resp_err    = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Scenario-driven scoreboard bench for lsu_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_memop;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [69:0] mem_vec;

    lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_memop     (req_memop),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_vec = {mem_req_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] memop);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_memop = memop;
    endtask

    task automatic idle_req;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_memop = '0;
    endtask

    task automatic test_reset;
        idle_req();
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        rst           = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_vec} !== {1'b1, 1'b0, 1'b0, 32'h0, 70'h0}) begin
            failures++;
            $display("FAIL reset_held: ready=%b rv=%b err=%b rdata=%h mem=%h, expected ready=1 and all else 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_vec);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({req_ready, resp_valid, mem_req_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_released: ready/rv/mrv=%b expected 100", {req_ready, resp_valid, mem_req_valid});
        end
    endtask

    task automatic test_store_byte;
        mem_req_ready = 1'b1;
        drive_req(1'b1, 32'h0000_1003, 32'h0000_00A5, MEMOP_B);
        exp_q.push_back('{32'h0, 1'b0});
        tick();
        idle_req();
        checks++;
        if (mem_vec !== {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
            failures++;
            $display("FAIL store_byte_bus: got %h expected %h", mem_vec,
                     {1'b1, 1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5});
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++;
            $display("FAIL store_byte_resp: got v=%b err=%b rdata=%h expected v=1 err=%b rdata=%h",
                     resp_valid, resp_err, resp_rdata, e.err, e.rdata);
        end
        tick();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL store_byte_after: rv/ready=%b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [2:0] memop,
                             input logic [31:0] rdata, input logic [31:0] expv);
        mem_req_ready = 1'b1;
        drive_req(1'b0, addr, 32'h0, memop);
        exp_q.push_back('{expv, 1'b0});
        tick();
        idle_req();
        checks++;
        if (mem_vec !== {1'b1, 1'b0, addr[31:2], 2'b00, 4'b0000, 32'h0}) begin
            failures++;
            $display("FAIL %s_bus: got %h expected %h", name, mem_vec,
                     {1'b1, 1'b0, addr[31:2], 2'b00, 4'b0000, 32'h0});
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++;
            $display("FAIL %s_resp: got v=%b err=%b rdata=%h expected v=1 err=%b rdata=%h",
                     name, resp_valid, resp_err, resp_rdata, e.err, e.rdata);
        end
        tick();
    endtask

    task automatic test_load_word_stall;
        mem_req_ready = 1'b0;
        drive_req(1'b0, 32'h0000_3008, 32'h0, MEMOP_W);
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) idle_req();
            checks++;
            if ({mem_vec, req_ready, resp_valid} !== {1'b1, 1'b0, 32'h0000_3008, 4'b0000, 32'h0, 2'b00}) begin
                failures++;
                $display("FAIL stall_req_cycle%0d: mem=%h ready=%b rv=%b expected stable request, ready=0",
                         i + 1, mem_vec, req_ready, resp_valid);
            end
        end
        mem_req_ready = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            checks++;
            if ({mem_req_valid, req_ready, resp_valid} !== 3'b000) begin
                failures++;
                $display("FAIL stall_wait_cycle%0d: mrv/ready/rv=%b expected 000", j,
                         {mem_req_valid, req_ready, resp_valid});
            end
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, e.err, e.rdata, 1'b0}) begin
            failures++;
            $display("FAIL stall_resp: got v=%b err=%b rdata=%h ready=%b expected v=1 err=%b rdata=%h ready=0",
                     resp_valid, resp_err, resp_rdata, req_ready, e.err, e.rdata);
        end
        tick();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL stall_after: rv/ready=%b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_error(input string name, input logic wen, input logic [31:0] addr,
                              input logic [2:0] memop);
        mem_req_ready = 1'b1;
        drive_req(wen, addr, 32'h1234_5678, memop);
        exp_q.push_back('{32'h0, 1'b1});
        tick();
        idle_req();
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata, mem_req_valid} !== {1'b1, e.err, e.rdata, 1'b0}) begin
            failures++;
            $display("FAIL %s_resp: got v=%b err=%b rdata=%h mrv=%b expected v=1 err=%b rdata=%h mrv=0",
                     name, resp_valid, resp_err, resp_rdata, mem_req_valid, e.err, e.rdata);
        end
        tick();
        checks++;
        if ({mem_req_valid, resp_valid, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL %s_after: mrv/rv/ready=%b expected 001", name,
                     {mem_req_valid, resp_valid, req_ready});
        end
    endtask

    task automatic test_timeout;
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b0;
        drive_req(1'b0, 32'h0000_0040, 32'h0, MEMOP_W);
        exp_q.push_back('{32'h0, 1'b1});
        tick();
        idle_req();
        for (int i = 0; i < TMO; i++) begin
            tick();
            checks++;
            if ({resp_valid, mem_req_valid, req_ready} !== 3'b000) begin
                failures++;
                $display("FAIL timeout_wait%0d: rv/mrv/ready=%b expected 000", i,
                         {resp_valid, mem_req_valid, req_ready});
            end
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++;
            $display("FAIL timeout_resp: got v=%b err=%b rdata=%h expected v=1 err=%b rdata=%h",
                     resp_valid, resp_err, resp_rdata, e.err, e.rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        mem_req_ready = 1'b1;
        drive_req(1'b1, 32'h0000_5002, 32'h1234_BEEF, MEMOP_H);
        exp_q.push_back('{32'h0, 1'b0});
        tick();
        idle_req();
        checks++;
        if (mem_vec !== {1'b1, 1'b1, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF}) begin
            failures++;
            $display("FAIL b2b_store_bus: got %h expected %h", mem_vec,
                     {1'b1, 1'b1, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF});
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, e.err, e.rdata, 1'b0}) begin
            failures++;
            $display("FAIL b2b_store_resp: got v=%b err=%b rdata=%h ready=%b expected v=1 err=%b rdata=%h ready=0",
                     resp_valid, resp_err, resp_rdata, req_ready, e.err, e.rdata);
        end
        drive_req(1'b0, 32'h0000_6001, 32'h0, MEMOP_BU);
        exp_q.push_back('{32'h0000_009A, 1'b0});
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got %b expected 1", req_ready);
        end
        tick();
        idle_req();
        checks++;
        if (mem_vec !== {1'b1, 1'b0, 32'h0000_6000, 4'b0000, 32'h0}) begin
            failures++;
            $display("FAIL b2b_load_bus: got %h expected %h", mem_vec,
                     {1'b1, 1'b0, 32'h0000_6000, 4'b0000, 32'h0});
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_9A00;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        e = exp_q.pop_front();
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, e.err, e.rdata}) begin
            failures++;
            $display("FAIL b2b_load_resp: got v=%b err=%b rdata=%h expected v=1 err=%b rdata=%h",
                     resp_valid, resp_err, resp_rdata, e.err, e.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        mem_req_ready = 1'b1;
        drive_req(1'b0, 32'h0000_0080, 32'h0, MEMOP_W);
        tick();
        idle_req();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        checks++;
        if ({req_ready, resp_valid, mem_req_valid} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_idle: ready/rv/mrv=%b expected 100", {req_ready, resp_valid, mem_req_valid});
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({resp_valid, req_ready, mem_req_valid} !== 3'b010) begin
                failures++;
                $display("FAIL rst_mid_after%0d: rv/ready/mrv=%b expected 010", i,
                         {resp_valid, req_ready, mem_req_valid});
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_byte();
        test_load("half_signed",   32'h0000_2002, MEMOP_H,  32'h8001_1234, 32'hFFFF_8001);
        test_load("half_unsigned", 32'h0000_2002, MEMOP_HU, 32'h8001_1234, 32'h0000_8001);
        test_load("byte_signed",   32'h0000_7003, MEMOP_B,  32'h8011_2233, 32'hFFFF_FF80);
        test_load("word",          32'h0000_7004, MEMOP_W,  32'h0BAD_F00D, 32'h0BAD_F00D);
        test_load_word_stall();
        test_error("misaligned_word", 1'b0, 32'h0000_3001, MEMOP_W);
        test_error("illegal_111",     1'b0, 32'h0000_3000, 3'b111);
        test_error("misaligned_half", 1'b1, 32'h0000_3003, MEMOP_H);
        test_error("illegal_011",     1'b1, 32'h0000_3000, 3'b011);
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
